// File: rtl/ht_tg_pkg.sv
// Shared types and pure helpers for the hash-table traffic generator.
// Latency: n/a (package only: types, constants, combinational functions).
// Backpressure: n/a.
package ht_tg_pkg;

    // Same encoding as the hash_table command channel.
    typedef enum logic [1:0] {
        HT_SEARCH = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2
    } ht_opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tg_state_t;

    // Right-shifting Galois toggle mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Smallest 2^n-1 that is >= m.
    function automatic logic [31:0] pow2_mask(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r = r | (r >> 1);
        r = r | (r >> 2);
        r = r | (r >> 4);
        r = r | (r >> 8);
        r = r | (r >> 16);
        return r;
    endfunction

    // Masking first bounds raw to <= 2*max+1, so a single subtract lands in 0..max.
    function automatic logic [31:0] range_fold(input logic [31:0] raw, input logic [31:0] max);
        logic [31:0] r;
        r = raw & pow2_mask(max);
        if (r > max)
            r = r - (max + 32'd1);
        return r;
    endfunction

    // v==3 aliases to SEARCH; a disabled pick walks forward cyclically to the next enabled op.
    function automatic ht_opcode_t op_select(input logic [1:0] v, input logic [2:0] mask);
        logic [1:0] idx;
        logic       found;
        ht_opcode_t op;
        idx   = (v == 2'd3) ? 2'd0 : v;
        found = 1'b0;
        op    = HT_SEARCH;
        for (int i = 0; i < 3; i++) begin
            if (!found && mask[idx]) begin
                op    = ht_opcode_t'(idx);
                found = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return op;
    endfunction

    // Sweep order per key: 0=INSERT, 1=SEARCH, 2=DELETE.
    function automatic ht_opcode_t seq_op(input logic [1:0] idx);
        case (idx)
            2'd0:    return HT_INSERT;
            2'd1:    return HT_SEARCH;
            default: return HT_DELETE;
        endcase
    endfunction

    // mask bit layout is {DELETE, INSERT, SEARCH}.
    function automatic logic seq_en(input logic [1:0] idx, input logic [2:0] mask);
        case (idx)
            2'd0:    return mask[1];
            2'd1:    return mask[0];
            default: return mask[2];
        endcase
    endfunction

endpackage

// File: rtl/ht_tg_lfsr.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
// Latency: load/advance visible on q the cycle after the request.
// Backpressure: none; holds its value when neither load nor advance is set.
// Ports: clk, rst (async, active-high), load/load_val, advance, q (current state).
module ht_tg_lfsr
    import ht_tg_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'hACE1_2345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        advance,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET_VAL;
        else if (load)
            q <= load_val;
        else if (advance)
            q <= lfsr_step(q);
    end

endmodule

// File: rtl/ht_traffic_gen.sv
// Hash-table command generator (random or sequential sweep) with result counting and drain timeout.
// Latency: first command valid one cycle after start_i; next command registered on each accept.
// Backpressure: cmd_valid_o and payload hold until cmd_ready_i; results always accepted (res_ready_o=1).
// Ports: clk_i/rst_i; run control start_i/abort_i/mode_i/op_mask_i/num_cmds_i/max_bucket_i/max_key_i/seed_i;
//        command channel cmd_*; result channel res_valid_i/res_ready_o;
//        status busy_o/done_o/timeout_o/err_o and per-run sent_cnt_o/recv_cnt_o.
module ht_traffic_gen
    import ht_tg_pkg::*;
#(
    parameter int          KEY_WIDTH      = 32,
    parameter int          VALUE_WIDTH    = 16,
    parameter int          BUCKET_WIDTH   = 8,
    parameter int          CNT_WIDTH      = 16,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2345
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic                              mode_i,
    input  logic [2:0]                        op_mask_i,
    input  logic [CNT_WIDTH-1:0]              num_cmds_i,
    input  logic [BUCKET_WIDTH-1:0]           max_bucket_i,
    input  logic [KEY_WIDTH-BUCKET_WIDTH-1:0] max_key_i,
    input  logic [31:0]                       seed_i,
    output logic                              cmd_valid_o,
    input  logic                              cmd_ready_i,
    output ht_opcode_t                        cmd_opcode_o,
    output logic [KEY_WIDTH-1:0]              cmd_key_o,
    output logic [VALUE_WIDTH-1:0]            cmd_value_o,
    input  logic                              res_valid_i,
    output logic                              res_ready_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              timeout_o,
    output logic                              err_o,
    output logic [CNT_WIDTH-1:0]              sent_cnt_o,
    output logic [CNT_WIDTH-1:0]              recv_cnt_o
);

    localparam int KLW = KEY_WIDTH - BUCKET_WIDTH;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    tg_state_t state_q, state_nxt;

    logic                    cmd_valid_q;
    ht_opcode_t              cmd_op_q;
    logic [KEY_WIDTH-1:0]    cmd_key_q;
    logic [VALUE_WIDTH-1:0]  cmd_val_q;
    logic [CNT_WIDTH-1:0]    sent_q, recv_q;
    logic                    done_q, err_q, timeout_q, abort_q;
    logic [TW-1:0]           idle_q;

    // Run configuration captured at start.
    logic                    mode_q;
    logic [2:0]              mask_q;
    logic [CNT_WIDTH-1:0]    num_q;
    logic [BUCKET_WIDTH-1:0] maxb_q;
    logic [KLW-1:0]          maxk_q;

    // Sweep position of the next command to generate.
    logic [1:0]              seq_ph_q;
    logic [BUCKET_WIDTH-1:0] seq_b_q;
    logic [KLW-1:0]          seq_k_q;

    logic [31:0]             lfsr_q;

    // FSM decisions.
    logic start_go, start_zero, start_bad, gen_next, to_drain, drain_done, drain_tmo;

    logic                 accept, last_accept, abort_any;
    logic [CNT_WIDTH-1:0] sent_inc, recv_inc;

    assign accept      = cmd_valid_q & cmd_ready_i;
    assign sent_inc    = (&sent_q) ? sent_q : sent_q + CNT_WIDTH'(1);
    assign recv_inc    = (&recv_q) ? recv_q : recv_q + CNT_WIDTH'(1);
    assign last_accept = (sent_inc == num_q);
    // Latched so a short abort pulse during a stall is not lost.
    assign abort_any   = abort_i | abort_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt  = state_q;
        start_go   = 1'b0;
        start_zero = 1'b0;
        start_bad  = 1'b0;
        gen_next   = 1'b0;
        to_drain   = 1'b0;
        drain_done = 1'b0;
        drain_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start_i && !done_q) begin
                    if (op_mask_i == 3'b000)
                        start_bad = 1'b1;
                    else if (num_cmds_i == '0)
                        start_zero = 1'b1;
                    else begin
                        start_go  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_accept || abort_any) begin
                        to_drain  = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        gen_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (recv_q >= sent_q) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (!res_valid_i && idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    drain_tmo = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // During the start cycle the generator works from the live inputs; afterwards from the latched copy.
    logic                    cfg_mode;
    logic [2:0]              cfg_mask;
    logic [BUCKET_WIDTH-1:0] cfg_maxb;
    logic [KLW-1:0]          cfg_maxk;
    logic [31:0]             seed_eff, gen_src;

    assign cfg_mode = start_go ? mode_i       : mode_q;
    assign cfg_mask = start_go ? op_mask_i    : mask_q;
    assign cfg_maxb = start_go ? max_bucket_i : maxb_q;
    assign cfg_maxk = start_go ? max_key_i    : maxk_q;
    assign seed_eff = (seed_i == 32'h0) ? LFSR_SEED : seed_i;
    // The first command uses the seed itself; the LFSR is loaded one step ahead of it.
    assign gen_src  = start_go ? seed_eff : lfsr_q;

    ht_tg_lfsr #(
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (start_go),
        .load_val (lfsr_step(seed_eff)),
        .advance  (gen_next),
        .q        (lfsr_q)
    );

    ht_opcode_t              gen_op;
    logic [KEY_WIDTH-1:0]    gen_key;
    logic [VALUE_WIDTH-1:0]  gen_val;
    logic [1:0]              first_ph, cur_ph, nxt_ph;
    logic [BUCKET_WIDTH-1:0] cur_b, nxt_b, rnd_b;
    logic [KLW-1:0]          cur_k, nxt_k, rnd_k;
    logic                    found;

    always_comb begin
        first_ph = 2'd0;
        cur_ph   = seq_ph_q;
        cur_b    = seq_b_q;
        cur_k    = seq_k_q;
        nxt_ph   = seq_ph_q;
        nxt_b    = seq_b_q;
        nxt_k    = seq_k_q;
        found    = 1'b0;
        rnd_b    = '0;
        rnd_k    = '0;
        gen_op   = HT_SEARCH;
        gen_key  = '0;
        gen_val  = '0;

        for (int i = 2; i >= 0; i--) begin
            if (seq_en(2'(i), cfg_mask))
                first_ph = 2'(i);
        end

        if (start_go) begin
            cur_ph = first_ph;
            cur_b  = '0;
            cur_k  = '0;
        end

        // Later enabled op on the same key, otherwise step the key and restart the op order.
        for (int i = 0; i < 3; i++) begin
            if (!found && 2'(i) > cur_ph && seq_en(2'(i), cfg_mask)) begin
                nxt_ph = 2'(i);
                found  = 1'b1;
            end
        end
        if (found) begin
            nxt_b = cur_b;
            nxt_k = cur_k;
        end else begin
            nxt_ph = first_ph;
            if (cur_k == cfg_maxk) begin
                nxt_k = '0;
                nxt_b = (cur_b == cfg_maxb) ? '0 : cur_b + BUCKET_WIDTH'(1);
            end else begin
                nxt_k = cur_k + KLW'(1);
                nxt_b = cur_b;
            end
        end

        rnd_b = BUCKET_WIDTH'(range_fold(32'(gen_src[31-:BUCKET_WIDTH]), 32'(cfg_maxb)));
        rnd_k = KLW'(range_fold(gen_src, 32'(cfg_maxk)));

        if (cfg_mode) begin
            gen_op  = seq_op(cur_ph);
            gen_key = {cur_b, cur_k};
            // Value tags the command with its index within the run.
            gen_val = start_go ? '0 : VALUE_WIDTH'(sent_inc);
        end else begin
            gen_op  = op_select(gen_src[9:8], cfg_mask);
            gen_key = {rnd_b, rnd_k};
            gen_val = gen_src[VALUE_WIDTH-1:0] ^ gen_src[31-:VALUE_WIDTH];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= HT_SEARCH;
            cmd_key_q   <= '0;
            cmd_val_q   <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
            idle_q      <= '0;
            mode_q      <= 1'b0;
            mask_q      <= '0;
            num_q       <= '0;
            maxb_q      <= '0;
            maxk_q      <= '0;
            seq_ph_q    <= '0;
            seq_b_q     <= '0;
            seq_k_q     <= '0;
        end else begin
            done_q <= drain_done | drain_tmo | start_zero;
            err_q  <= start_bad | ((state_q == IDLE) & res_valid_i);

            if (start_go || start_zero) begin
                sent_q    <= '0;
                recv_q    <= '0;
                timeout_q <= 1'b0;
                abort_q   <= 1'b0;
            end
            if (drain_tmo)
                timeout_q <= 1'b1;

            if (start_go) begin
                mode_q <= mode_i;
                mask_q <= op_mask_i;
                num_q  <= num_cmds_i;
                maxb_q <= max_bucket_i;
                maxk_q <= max_key_i;
            end

            if (start_go || gen_next) begin
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= gen_op;
                cmd_key_q   <= gen_key;
                cmd_val_q   <= gen_val;
                seq_ph_q    <= nxt_ph;
                seq_b_q     <= nxt_b;
                seq_k_q     <= nxt_k;
            end else if (to_drain) begin
                cmd_valid_q <= 1'b0;
            end

            if (state_q == RUN && accept)
                sent_q <= sent_inc;
            if (state_q != IDLE && res_valid_i)
                recv_q <= recv_inc;
            if (state_q == RUN && abort_i)
                abort_q <= 1'b1;

            if (state_q == DRAIN && !res_valid_i)
                idle_q <= idle_q + TW'(1);
            else
                idle_q <= '0;
        end
    end

    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_opcode_o = cmd_op_q;
    assign cmd_key_o    = cmd_key_q;
    assign cmd_value_o  = cmd_val_q;
    assign res_ready_o  = 1'b1;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign timeout_o    = timeout_q;
    assign err_o        = err_q;
    assign sent_cnt_o   = sent_q;
    assign recv_cnt_o   = recv_q;

endmodule

// File: tb/tb_ht_traffic_gen.sv
// Directed bench for ht_traffic_gen: sweep order, random constraints/reproducibility,
// ready backpressure, abort, drain timeout, start corner cases and reset during a run.
module tb_ht_traffic_gen;
    import ht_tg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, mode_i;
    logic [2:0]  op_mask_i;
    logic [15:0] num_cmds_i;
    logic [7:0]  max_bucket_i;
    logic [23:0] max_key_i;
    logic [31:0] seed_i;
    logic        cmd_valid_o, cmd_ready_i;
    ht_opcode_t  cmd_opcode_o;
    logic [31:0] cmd_key_o;
    logic [15:0] cmd_value_o;
    logic        res_valid_i, res_ready_o;
    logic        busy_o, done_o, timeout_o, err_o;
    logic [15:0] sent_cnt_o, recv_cnt_o;

    ht_traffic_gen dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .mode_i       (mode_i),
        .op_mask_i    (op_mask_i),
        .num_cmds_i   (num_cmds_i),
        .max_bucket_i (max_bucket_i),
        .max_key_i    (max_key_i),
        .seed_i       (seed_i),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_ready_i  (cmd_ready_i),
        .cmd_opcode_o (cmd_opcode_o),
        .cmd_key_o    (cmd_key_o),
        .cmd_value_o  (cmd_value_o),
        .res_valid_i  (res_valid_i),
        .res_ready_o  (res_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .err_o        (err_o),
        .sent_cnt_o   (sent_cnt_o),
        .recv_cnt_o   (recv_cnt_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int stab_err;

    // Record layout: {opcode[1:0], key[31:0], value[15:0]}.
    logic [49:0] got_q[$];
    logic [49:0] ref_q[$];
    logic [49:0] exp1 [6];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [49:0] payload();
        return {2'(cmd_opcode_o), cmd_key_o, cmd_value_o};
    endfunction

    task automatic start_run(input logic mode, input logic [2:0] mask, input logic [15:0] num,
                             input logic [7:0] mb, input logic [23:0] mk, input logic [31:0] seed);
        mode_i       = mode;
        op_mask_i    = mask;
        num_cmds_i   = num;
        max_bucket_i = mb;
        max_key_i    = mk;
        seed_i       = seed;
        start_i      = 1'b1;
        step();
        start_i      = 1'b0;
    endtask

    // Accepts commands until valid drops, answering each accept with one result beat a cycle later.
    task automatic drive_run(input bit rand_ready, input int limit);
        logic        prev_acc, held_vld, rdy;
        logic [49:0] held, cur;
        prev_acc = 1'b0;
        held_vld = 1'b0;
        held     = '0;
        stab_err = 0;
        for (int c = 0; c < limit; c++) begin
            res_valid_i = prev_acc;
            if (!cmd_valid_o)
                break;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_ready_i = rdy;
            cur = payload();
            if (held_vld && cur !== held)
                stab_err++;
            if (rdy)
                got_q.push_back(cur);
            prev_acc = rdy;
            held     = cur;
            held_vld = !rdy;
            step();
        end
        step();
        res_valid_i = 1'b0;
        cmd_ready_i = 1'b1;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit          seen;
        int          viol, mism, cyc, bad, vcnt;
        logic [2:0]  ops_seen;
        logic [49:0] snap, e;

        exp1[0] = {2'd1, 32'h0, 16'd0};
        exp1[1] = {2'd0, 32'h0, 16'd1};
        exp1[2] = {2'd2, 32'h0, 16'd2};
        exp1[3] = {2'd1, 32'h1, 16'd3};
        exp1[4] = {2'd0, 32'h1, 16'd4};
        exp1[5] = {2'd2, 32'h1, 16'd5};

        rst = 1'b1; start_i = 0; abort_i = 0; mode_i = 0; op_mask_i = 0; num_cmds_i = 0;
        max_bucket_i = 0; max_key_i = 0; seed_i = 0; cmd_ready_i = 0; res_valid_i = 0;
        #2;
        check("rst_valid", cmd_valid_o, 0);
        check("rst_res_ready", res_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_err", err_o, 0);
        check("rst_payload", payload(), 0);
        check("rst_sent", sent_cnt_o, 0);
        check("rst_recv", recv_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: sequential sweep, two keys x three ops.
        cmd_ready_i = 1'b1;
        start_run(1'b1, 3'b111, 16'd6, 8'd1, 24'd1, 32'd0);
        check("t1_first_valid", cmd_valid_o, 1);
        check("t1_busy", busy_o, 1);
        got_q.delete();
        drive_run(1'b0, 50);
        check("t1_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            e = (i < got_q.size()) ? got_q[i] : '1;
            check($sformatf("t1_cmd%0d", i), e, exp1[i]);
        end
        check("t1_no_valid_after_last", cmd_valid_o, 0);
        wait_done(20, seen);
        check("t1_done", seen, 1);
        check("t1_sent", sent_cnt_o, 6);
        check("t1_recv", recv_cnt_o, 6);
        check("t1_timeout", timeout_o, 0);
        step();
        check("t1_done_pulse", done_o, 0);

        // 2: random mode constraints and reproducibility.
        start_run(1'b0, 3'b111, 16'd5000, 8'd15, 24'd7, 32'd1);
        got_q.delete();
        drive_run(1'b0, 6000);
        check("t2_count", got_q.size(), 5000);
        check("t2_cmd0", (got_q.size() > 0) ? got_q[0] : '1, {2'd0, 32'h0000_0001, 16'h0001});
        check("t2_cmd1", (got_q.size() > 1) ? got_q[1] : '1, {2'd0, 32'h0000_0003, 16'h8023});
        check("t2_cmd2", (got_q.size() > 2) ? got_q[2] : '1, {2'd0, 32'h0000_0002, 16'hC032});
        viol = 0;
        ops_seen = 3'b000;
        foreach (got_q[i]) begin
            if (got_q[i][47:40] > 8'd15 || got_q[i][39:16] > 24'd7)
                viol++;
            if (got_q[i][49:48] < 2'd3)
                ops_seen[got_q[i][49:48]] = 1'b1;
        end
        check("t2_key_range", viol, 0);
        check("t2_ops_seen", ops_seen, 3'b111);
        wait_done(20, seen);
        check("t2_done", seen, 1);
        check("t2_recv", recv_cnt_o, 5000);
        ref_q = got_q;
        step();
        start_run(1'b0, 3'b111, 16'd5000, 8'd15, 24'd7, 32'd1);
        got_q.delete();
        drive_run(1'b0, 6000);
        mism = (got_q.size() == ref_q.size()) ? 0 : 1;
        foreach (ref_q[i])
            if (i < got_q.size() && got_q[i] !== ref_q[i])
                mism++;
        check("t2_rerun_identical", mism, 0);
        wait_done(20, seen);
        check("t2_rerun_done", seen, 1);
        step();

        // 3: random ready backpressure on a sweep with bucket wrap.
        start_run(1'b1, 3'b011, 16'd40, 8'd3, 24'd2, 32'd0);
        got_q.delete();
        drive_run(1'b1, 400);
        check("t3_stable", stab_err, 0);
        check("t3_count", got_q.size(), 40);
        mism = 0;
        for (int n = 0; n < 40; n++) begin
            e = {(n % 2 == 0) ? 2'd1 : 2'd0, 8'((n / 2 / 3) % 4), 24'((n / 2) % 3), 16'(n)};
            if (n >= got_q.size() || got_q[n] !== e)
                mism++;
        end
        check("t3_sequence", mism, 0);
        wait_done(20, seen);
        check("t3_done", seen, 1);
        check("t3_sent", sent_cnt_o, 40);
        check("t3_recv", recv_cnt_o, 40);
        step();

        // 4: abort while a command is stalled.
        cmd_ready_i = 1'b1;
        start_run(1'b1, 3'b111, 16'd20, 8'd0, 24'hFF, 32'd0);
        step(); step(); step();
        cmd_ready_i = 1'b0;
        abort_i     = 1'b1;
        snap = payload();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!cmd_valid_o || payload() !== snap)
                bad++;
        end
        check("t4_held", bad, 0);
        check("t4_pending_payload", snap, {2'd1, 32'h1, 16'd3});
        check("t4_sent_before", sent_cnt_o, 3);
        cmd_ready_i = 1'b1;
        step();
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (cmd_valid_o)
                vcnt++;
            step();
        end
        check("t4_no_more_valid", vcnt, 0);
        check("t4_sent_after", sent_cnt_o, 4);
        check("t4_drain_busy", busy_o, 1);
        check("t4_drain_not_done", done_o, 0);
        abort_i     = 1'b0;
        res_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        res_valid_i = 1'b0;
        wait_done(10, seen);
        check("t4_done", seen, 1);
        check("t4_recv", recv_cnt_o, 4);
        step();

        // 5: drain timeout, sticky until next start.
        cmd_ready_i = 1'b1;
        start_run(1'b1, 3'b111, 16'd2, 8'd0, 24'd0, 32'd0);
        step(); step();
        check("t5_valid_low", cmd_valid_o, 0);
        cyc = -1;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (done_o) begin
                cyc = c;
                break;
            end
        end
        check("t5_timeout_cycles", cyc, 1024);
        check("t5_timeout", timeout_o, 1);
        check("t5_busy", busy_o, 0);
        step();
        check("t5_timeout_sticky", timeout_o, 1);
        check("t5_done_pulse", done_o, 0);
        start_run(1'b1, 3'b111, 16'd1, 8'd0, 24'd0, 32'd0);
        check("t5_timeout_cleared", timeout_o, 0);
        drive_run(1'b0, 10);
        wait_done(10, seen);
        check("t5_rerun_done", seen, 1);
        step();

        // 6: start corner cases.
        mode_i = 1'b1; op_mask_i = 3'b111; num_cmds_i = 16'd0; start_i = 1'b1;
        step();
        check("t6_zero_done", done_o, 1);
        check("t6_zero_busy", busy_o, 0);
        check("t6_zero_err", err_o, 0);
        check("t6_zero_valid", cmd_valid_o, 0);
        step();
        start_i = 1'b0;
        check("t6_start_during_done_ignored", done_o, 0);
        start_run(1'b0, 3'b000, 16'd5, 8'd0, 24'd0, 32'd0);
        check("t6_mask0_err", err_o, 1);
        check("t6_mask0_done", done_o, 0);
        check("t6_mask0_busy", busy_o, 0);
        step();
        check("t6_err_pulse", err_o, 0);
        res_valid_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        check("t6_idle_res_err", err_o, 1);
        check("t6_idle_res_uncounted", recv_cnt_o, 0);

        // Range fold (6 > 5 -> 0) and op fallback to the only enabled op.
        start_run(1'b0, 3'b100, 16'd1, 8'd0, 24'd5, 32'd6);
        check("t6_fold_payload", payload(), {2'd2, 32'h0, 16'h0006});
        drive_run(1'b0, 10);
        wait_done(10, seen);
        check("t6_fold_done", seen, 1);
        step();

        // Seed 0 selects the default seed.
        start_run(1'b0, 3'b111, 16'd1, 8'hFF, 24'hFF_FFFF, 32'd0);
        check("t6_default_seed", payload(), {2'd0, 32'hACE1_2345, 16'h8FA4});
        drive_run(1'b0, 10);
        wait_done(10, seen);
        check("t6_default_done", seen, 1);
        step();

        // Reset in RUN.
        cmd_ready_i = 1'b0;
        start_run(1'b1, 3'b111, 16'd100, 8'd0, 24'd0, 32'd0);
        check("t6_run_valid", cmd_valid_o, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", cmd_valid_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_sent", sent_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("t6_post_rst_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ht_traffic_gen.md
Name: ht_traffic_gen

Overview:
- Synthesizable hash-table command generator and response counter, parametrised in key, value and bucket widths.
- Drives the hash_table_top command channel with a programmable number of SEARCH/INSERT/DELETE commands.
- Two modes: random (LFSR-based, bucket- and key-range constrained), or a sequential key sweep.
- Counts results and reports completion or timeout; used for on-chip and long-run regression stress.

Parameters:
KEY_WIDTH, 32, key width (matches hash_table package)
VALUE_WIDTH, 16, value width
BUCKET_WIDTH, 8, bucket field = key MSBs (dummy hash)
CNT_WIDTH, 16, command/response counter width
TIMEOUT_CYCLES, 1024, max idle cycles in DRAIN before abort
LFSR_SEED, 32'hACE1_2345, default nonzero seed

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
start_i  in  1  pulse; starts a run when IDLE
abort_i  in  1  level; stop issuing, go to DRAIN
mode_i  in  1  0=random, 1=sequential sweep
op_mask_i  in  3  enable {DELETE,INSERT,SEARCH}
num_cmds_i  in  CNT_WIDTH  commands per run
max_bucket_i  in  BUCKET_WIDTH  inclusive bucket limit
max_key_i  in  KEY_WIDTH-BUCKET_WIDTH  inclusive low-key limit
seed_i  in  32  LFSR seed; 0 selects LFSR_SEED
cmd_valid_o  out  1  command valid
cmd_ready_i  in  1  command accepted when valid&ready
cmd_opcode_o  out  ht_opcode_t  opcode
cmd_key_o  out  KEY_WIDTH  key
cmd_value_o  out  VALUE_WIDTH  value
res_valid_i  in  1  result beat
res_ready_o  out  1  constant 1
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of run
timeout_o  out  1  sticky until next start; DRAIN timed out
err_o  out  1  one-cycle pulse: start with op_mask_i==0, or res_valid_i while IDLE
sent_cnt_o  out  CNT_WIDTH  commands accepted this run
recv_cnt_o  out  CNT_WIDTH  results counted this run

Behaviour:
- Reset: clk_i single clock; rst_i asynchronous, active-high. All outputs 0 except res_ready_o=1; state IDLE; LFSR=LFSR_SEED.
- States:
  - IDLE: start_i, mask!=0, num!=0 -> RUN. Latch config; load seed; clear counters and timeout_o. First cmd_valid_o 1 cycle after start_i.
  - IDLE: start_i with num==0 -> done_o next cycle, stay IDLE.
  - IDLE: start_i with mask==0 -> err_o, stay IDLE.
  - RUN: issue commands. Last accept (sent == num) or abort -> DRAIN.
  - DRAIN: recv >= sent -> IDLE + done_o. TIMEOUT_CYCLES consecutive cycles without res_valid_i -> IDLE + done_o + timeout_o.
  - start_i is ignored unless IDLE.
- Handshake:
  - Once cmd_valid_o rises, it and the payload are held stable until accepted; abort never drops a pending command.
  - Next command is registered on accept, so throughput is 1 cmd/cycle with ready=1.
  - No valid after the final accept.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. Advances once per generated command. Runs are reproducible for a given seed.
- Random mode:
  - raw_b = lfsr[31-:BUCKET_WIDTH]; raw_k = lfsr low bits masked to next power-of-two-minus-1 >= max.
  - Range fold: if raw > max, use raw-(max+1). Result is always <= max.
  - Op: v=lfsr[9:8], 3->0, mapping 0=SEARCH, 1=INSERT, 2=DELETE. If v is disabled, take the next enabled op cyclically.
  - Value = lfsr[VALUE_WIDTH-1:0] ^ lfsr[31-:VALUE_WIDTH].
- Sequential mode:
  - Per key, issue enabled ops in order INSERT, SEARCH, DELETE, then advance the key.
  - Low key counts 0..max_key_i; on wrap, bucket increments 0..max_bucket_i, then wraps to 0.
  - Value = sent_cnt low bits.
- Key = {bucket, low}.
- Counters saturate at all-ones. recv_cnt counts res_valid_i in RUN/DRAIN; results in IDLE raise err_o and are not counted.
- Simultaneous: accept of last command plus abort -> DRAIN once. start_i in the same cycle as done_o is ignored.

Decomposition:
- Package ht_tg_pkg: tg_state_t {IDLE,RUN,DRAIN}; LFSR step function; range-fold function; op-select function. Opcodes are reused from hash_table.
- Sub-module ht_tg_lfsr: load/advance, 32-bit output.

Test Plan:
1. Sequential, mask=3'b111, num=6, max_bucket=1, max_key=1, ready=1 -> exactly (INS,SRCH,DEL) on key 0x00000000, then (INS,SRCH,DEL) on 0x00000001. Values 0..5; done_o after 6 results; sent=recv=6.
2. Random, seed=1, num=5000, max_bucket=15, max_key=7 -> every key satisfies key[31:24]<=15 and key[23:0]<=7; all three opcodes seen; a rerun with the same seed is bit-identical.
3. cmd_ready_i toggled pseudo-randomly -> payload stable while valid&!ready; no command lost or duplicated; sent=num.
4. abort_i asserted mid-run with ready=0 -> pending command still accepted, then none further; DRAIN waits for recv=sent, then done_o.
5. Responses withheld after the last command -> after 1024 idle cycles, done_o and timeout_o=1; next start_i clears timeout_o.
6. start_i with num=0 -> done_o only. start_i with mask=0 -> err_o only. rst_i asserted in RUN -> cmd_valid_o=0 immediately, state IDLE.
